// File: rtl/micro_op_queue.sv
// Circular micro-op queue: accepts whole decode bundles (0..MAX_MOP_CNT mops)
// and streams them one per cycle, in program order, tagging each instruction's last mop.
module micro_op_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned MAX_MOP_CNT = 6,
  parameter int unsigned MOP_W       = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 in_valid,
  input  logic [2:0]                           in_cnt,
  input  logic [0:MAX_MOP_CNT-1][MOP_W-1:0]    in_mops,
  output logic                                 in_ready,
  output logic                                 out_valid,
  output logic [MOP_W-1:0]                     out_mop,
  output logic                                 out_last,
  input  logic                                 out_ready,
  output logic [$clog2(DEPTH):0]               occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [MOP_W-1:0] mem_q [DEPTH];
  logic [MOP_W-1:0] mem_d [DEPTH];
  logic             last_q [DEPTH];
  logic             last_d [DEPTH];
  logic             push;
  logic             pop;

  // Status is derived from registered count only, so a same-cycle pop never widens in_ready.
  always_comb begin
    in_ready  = count_q <= CNT_W'(DEPTH - MAX_MOP_CNT);
    out_valid = count_q != '0;
    out_mop   = mem_q[head_q];
    out_last  = out_valid && last_q[head_q];
    occupancy = count_q;
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    last_d  = last_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        // Writes land only in free slots, so they never collide with the head being popped.
        for (int unsigned i = 0; i < MAX_MOP_CNT; i++) begin
          if (i < 32'(in_cnt)) begin
            mem_d[tail_q + PTR_W'(i)]  = in_mops[i];
            last_d[tail_q + PTR_W'(i)] = (i == 32'(in_cnt) - 32'd1);
          end
        end
        tail_d = tail_q + PTR_W'(in_cnt);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + (push ? CNT_W'(in_cnt) : CNT_W'(0)) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity comes from count.
  always_ff @(posedge clk) begin
    mem_q  <= mem_d;
    last_q <= last_d;
  end

  // Bundle sizes beyond MAX_MOP_CNT indicate a broken producer.
  always_ff @(posedge clk) begin
    if (!reset && in_valid && (32'(in_cnt) > MAX_MOP_CNT)) begin
      $error("micro_op_queue: illegal in_cnt %0d", in_cnt);
      $finish;
    end
  end

endmodule

// File: tb/tb_micro_op_queue.sv
// Directed bench for micro_op_queue: vector table for basic flow/backpressure,
// hand sequences for wrap, push+pop, nop bundles, flush and async reset.
module tb_micro_op_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned MAXC  = 6;
  localparam int unsigned MW    = 16;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      flush;
  logic                      in_valid;
  logic [2:0]                in_cnt;
  logic [0:MAXC-1][MW-1:0]   in_mops;
  logic                      in_ready;
  logic                      out_valid;
  logic [MW-1:0]             out_mop;
  logic                      out_last;
  logic                      out_ready;
  logic [4:0]                occupancy;

  int checks = 0;
  int errors = 0;

  micro_op_queue #(.DEPTH(DEPTH), .MAX_MOP_CNT(MAXC), .MOP_W(MW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_cnt(in_cnt),
    .in_mops(in_mops), .in_ready(in_ready), .out_valid(out_valid), .out_mop(out_mop),
    .out_last(out_last), .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [2:0]  cnt;
    logic [15:0] base;
    logic        ordy;
    logic [4:0]  occ;
    logic        vld;
    logic [15:0] mop;
    logic        lst;
    logic        ird;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [2:0] cnt,
                              input logic [15:0] base, input logic ordy, input logic [4:0] occ,
                              input logic vld, input logic [15:0] mop, input logic lst,
                              input logic ird);
    vec_t v;
    v.fl = fl; v.iv = iv; v.cnt = cnt; v.base = base; v.ordy = ordy;
    v.occ = occ; v.vld = vld; v.mop = mop; v.lst = lst; v.ird = ird;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic [4:0] occ, input logic vld,
                           input logic [15:0] mop, input logic lst, input logic ird);
    chk({nm, ".occupancy"}, 32'(occupancy), 32'(occ));
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(vld));
    chk({nm, ".out_last"},  32'(out_last),  32'(lst));
    chk({nm, ".in_ready"},  32'(in_ready),  32'(ird));
    if (vld) chk({nm, ".out_mop"}, 32'(out_mop), 32'(mop));
  endtask

  // Drive one cycle of inputs, clock once, then compare post-edge outputs.
  task automatic step(input logic fl, input logic iv, input logic [2:0] cnt,
                      input logic [15:0] base, input logic ordy, input logic [4:0] occ,
                      input logic vld, input logic [15:0] mop, input logic lst,
                      input logic ird, input string nm);
    flush = fl; in_valid = iv; in_cnt = cnt; out_ready = ordy;
    for (int i = 0; i < int'(MAXC); i++) in_mops[i] = base + 16'(i);
    @(posedge clk);
    #1;
    check_out(nm, occ, vld, mop, lst, ird);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_cnt = 3'd0; out_ready = 1'b0;
    in_mops = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 5'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    reset = 1'b0;

    // Bundle of 4 streamed out; then backpressure fill, held bundle, drain.
    tbl.push_back(mk(0, 1, 4, 16'h10, 1,  4, 1, 16'h10, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  3, 1, 16'h11, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  2, 1, 16'h12, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  1, 1, 16'h13, 1, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  0, 0, 16'h00, 0, 1));
    tbl.push_back(mk(0, 1, 6, 16'h20, 0,  6, 1, 16'h20, 0, 1));
    tbl.push_back(mk(0, 1, 6, 16'h30, 0, 12, 1, 16'h20, 0, 0));
    tbl.push_back(mk(0, 1, 6, 16'h40, 0, 12, 1, 16'h20, 0, 0));
    tbl.push_back(mk(0, 1, 6, 16'h40, 1, 11, 1, 16'h21, 0, 0));
    tbl.push_back(mk(0, 1, 6, 16'h40, 1, 10, 1, 16'h22, 0, 1));
    tbl.push_back(mk(0, 1, 6, 16'h40, 0, 16, 1, 16'h22, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1, 15, 1, 16'h23, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1, 14, 1, 16'h24, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1, 13, 1, 16'h25, 1, 0));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1, 12, 1, 16'h30, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1, 11, 1, 16'h31, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1, 10, 1, 16'h32, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  9, 1, 16'h33, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  8, 1, 16'h34, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  7, 1, 16'h35, 1, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  6, 1, 16'h40, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  5, 1, 16'h41, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  4, 1, 16'h42, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  3, 1, 16'h43, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  2, 1, 16'h44, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  1, 1, 16'h45, 1, 1));
    tbl.push_back(mk(0, 0, 0, 16'h00, 1,  0, 0, 16'h00, 0, 1));

    foreach (tbl[i]) begin
      step(tbl[i].fl, tbl[i].iv, tbl[i].cnt, tbl[i].base, tbl[i].ordy,
           tbl[i].occ, tbl[i].vld, tbl[i].mop, tbl[i].lst, tbl[i].ird,
           $sformatf("vec%0d", i));
    end

    // Head/tail now at 6: move both to 14, then push a bundle that straddles the wrap.
    step(0, 1, 6, 16'h50, 0, 6, 1, 16'h50, 0, 1, "adv_a");
    step(0, 1, 2, 16'h60, 0, 8, 1, 16'h50, 0, 1, "adv_b");
    step(0, 0, 0, 16'h00, 1, 7, 1, 16'h51, 0, 1, "adv_p0");
    step(0, 0, 0, 16'h00, 1, 6, 1, 16'h52, 0, 1, "adv_p1");
    step(0, 0, 0, 16'h00, 1, 5, 1, 16'h53, 0, 1, "adv_p2");
    step(0, 0, 0, 16'h00, 1, 4, 1, 16'h54, 0, 1, "adv_p3");
    step(0, 0, 0, 16'h00, 1, 3, 1, 16'h55, 1, 1, "adv_p4");
    step(0, 0, 0, 16'h00, 1, 2, 1, 16'h60, 0, 1, "adv_p5");
    step(0, 0, 0, 16'h00, 1, 1, 1, 16'h61, 1, 1, "adv_p6");
    step(0, 0, 0, 16'h00, 1, 0, 0, 16'h00, 0, 1, "adv_p7");
    step(0, 1, 5, 16'h70, 0, 5, 1, 16'h70, 0, 1, "wrap_push");
    step(0, 0, 0, 16'h00, 1, 4, 1, 16'h71, 0, 1, "wrap_p0");
    step(0, 0, 0, 16'h00, 1, 3, 1, 16'h72, 0, 1, "wrap_p1");
    step(0, 0, 0, 16'h00, 1, 2, 1, 16'h73, 0, 1, "wrap_p2");
    step(0, 0, 0, 16'h00, 1, 1, 1, 16'h74, 1, 1, "wrap_p3");
    step(0, 0, 0, 16'h00, 1, 0, 0, 16'h00, 0, 1, "wrap_p4");

    // Simultaneous push of 3 and pop at count 2.
    step(0, 1, 2, 16'h80, 0, 2, 1, 16'h80, 0, 1, "pp_fill");
    step(0, 1, 3, 16'h90, 1, 4, 1, 16'h81, 1, 1, "pp_both");
    step(0, 0, 0, 16'h00, 1, 3, 1, 16'h90, 0, 1, "pp_p0");
    step(0, 0, 0, 16'h00, 1, 2, 1, 16'h91, 0, 1, "pp_p1");
    step(0, 0, 0, 16'h00, 1, 1, 1, 16'h92, 1, 1, "pp_p2");
    step(0, 0, 0, 16'h00, 1, 0, 0, 16'h00, 0, 1, "pp_p3");

    // Empty bundle handshake, then flush dropping a concurrent bundle and pop.
    step(0, 1, 6, 16'hA0, 0, 6, 1, 16'hA0, 0, 1, "fl_fill_a");
    step(0, 1, 1, 16'hB0, 0, 7, 1, 16'hA0, 0, 1, "fl_fill_b");
    step(0, 1, 0, 16'hC8, 0, 7, 1, 16'hA0, 0, 1, "nop_bundle");
    step(1, 1, 2, 16'hC0, 1, 0, 0, 16'h00, 0, 1, "flush");
    step(0, 0, 0, 16'h00, 1, 0, 0, 16'h00, 0, 1, "post_flush");
    step(0, 1, 1, 16'hD0, 0, 1, 1, 16'hD0, 1, 1, "flush_push");
    step(0, 0, 0, 16'h00, 1, 0, 0, 16'h00, 0, 1, "flush_pop");

    // Async reset asserted between edges with 9 mops held.
    step(0, 1, 6, 16'hE0, 0, 6, 1, 16'hE0, 0, 1, "rst_fill_a");
    step(0, 1, 3, 16'hF0, 0, 9, 1, 16'hE0, 0, 1, "rst_fill_b");
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", 5'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    #1;
    reset = 1'b0;
    step(0, 1, 1, 16'h99, 0, 1, 1, 16'h99, 1, 1, "rst_push");
    step(0, 0, 0, 16'h00, 1, 0, 0, 16'h00, 0, 1, "rst_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
